fan_ctrl_mc: RTL and testbench
==============================

FAN_CTRL_MC -- requirements
Module: fan_ctrl_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent fan channels.
REQ-002 SHALL have parameter PWM_BITWIDTH, default 8: width of period, duty and PWM counter.
REQ-003 SHALL have parameter PWM_CLK_DIV, default 15: prescaler terminal count; tick every PWM_CLK_DIV+1 enabled cycles.
REQ-004 SHALL have parameter SPINUP_PERIODS, default 16: number of full-duty PWM periods after leaving OFF.
REQ-005 SHALL have parameter TACH_WINDOW, default 2500: tach measurement window length, in PWM periods.
REQ-006 SHALL have parameter STALL_LIMIT, default 2: consecutive zero-edge windows in RUN that declare a stall.
REQ-007 SHALL have port clk_i, input, 1 bit: single clock.
REQ-008 SHALL have port rstn_i, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port clk_en_i, input, 1 bit: clock enable; all counters advance only when it is high.
REQ-010 SHALL have port period_i, input, PWM_BITWIDTH: PWM counter terminal value, shared by all channels.
REQ-011 SHALL have port wr_en_i, input, 1 bit: single-cycle register write strobe.
REQ-012 SHALL have port wr_ch_i, input, $clog2(NUM_CH) (minimum 1): target channel of the write.
REQ-013 SHALL have port wr_field_i, input, 2 bits: write field select; 0 = duty, 1 = min_duty, 2 and 3 ignored.
REQ-014 SHALL have port wr_data_i, input, PWM_BITWIDTH: write data.
REQ-015 SHALL have port tach_i, input, NUM_CH: asynchronous tachometer pulses.
REQ-016 SHALL have port pwm_o, output, NUM_CH: registered PWM outputs.
REQ-017 SHALL have port stall_o, output, NUM_CH: per-channel stall flag.
REQ-018 SHALL have port state_o, output, 2*NUM_CH: per-channel state; OFF=0, SPINUP=1, RUN=2, STALL=3; channel n occupies bits [2n+1:2n].
REQ-019 SHALL have port tach_cnt_o, output, 16*NUM_CH: per-channel edge count latched from the last completed window.

Function
REQ-020 Prescaler SHALL count 0..PWM_CLK_DIV on clk_en_i; tick = clk_en_i high and prescaler at PWM_CLK_DIV.
REQ-021 One shared PWM counter SHALL advance on each tick and wrap from period_i to 0; period_end = tick with counter equal to period_i.
REQ-022 Writes SHALL take effect on the cycle after wr_en_i; writes with wr_ch_i >= NUM_CH or wr_field_i >= 2 SHALL be ignored.
REQ-023 Effective compare value SHALL be: 0 in OFF and STALL; all-ones (output forced high) in SPINUP; max(duty, min_duty) in RUN.
REQ-024 Effective compare SHALL be loaded only at period_end, so there is no mid-period duty glitch.
REQ-025 pwm_o[n] SHALL be registered as (counter < compare); if compare > period_i, the output stays high continuously.
REQ-026 State transitions SHALL be evaluated only at period_end.
REQ-027 In every state, duty == 0 SHALL cause a transition to OFF, clear stall_o and clear the miss counter; this rule has priority over all others.
REQ-028 OFF -> SPINUP SHALL occur when duty != 0; the spin-up period counter is cleared.
REQ-029 SPINUP SHALL count period_ends and go to RUN on the SPINUP_PERIODS-th period_end after entry.
REQ-030 Tach inputs SHALL be synchronised with 2 flip-flops; a rising edge of the synchronised signal counts one edge.
REQ-031 The edge counter SHALL be 16 bits and saturate at 0xFFFF.
REQ-032 Window counter SHALL count period_ends 0..TACH_WINDOW-1; at window end every tach_cnt_o[n] SHALL latch its count and the counter restarts from 0, or from 1 if an edge occurs in that same cycle.
REQ-033 In RUN at window end: zero edges increments the miss counter; nonzero edges clears it; reaching STALL_LIMIT SHALL go to STALL and set stall_o.
REQ-034 Miss counting SHALL be inactive in OFF and SPINUP; the miss counter is cleared on entry to RUN.
REQ-035 STALL SHALL be left only via REQ-027 (duty written 0).
REQ-036 Window end and a state transition at the same period_end SHALL use the pre-transition state for miss evaluation.

Reset
REQ-037 While rstn_i is low at a clock edge, all counters, duty, min_duty, compare and tach_cnt_o SHALL be cleared to 0.
REQ-038 During reset all states SHALL go to OFF and pwm_o and stall_o SHALL be 0; reset mid-spin-up or mid-window SHALL abandon that progress.
REQ-039 Synchroniser flip-flops SHALL reset to 0.

Verification
REQ-040 Bench config PWM_CLK_DIV=0, period_i=3, clk_en_i=1: write duty=2 on ch0 -> after SPINUP_PERIODS periods high, pwm_o[0] is high 2 of every 4 cycles.
REQ-041 Write min_duty=3, duty=1 -> RUN compare is 3; duty=0 -> OFF at the next period_end, pwm_o low.
REQ-042 TACH_WINDOW=4, no tach edges in RUN -> STALL after 2 windows, stall_o=1, pwm_o=0; write duty=0 -> OFF, stall_o cleared.
REQ-043 5 tach pulses within one window -> tach_cnt_o for that channel reads 5 after the window end; a stuck-high tach counts as 1 edge.
REQ-044 Duty change mid-period -> pwm_o waveform changes only from the next period start.
REQ-045 Reset asserted during SPINUP -> state OFF, outputs 0; after release with duty still 0, the channel stays OFF.

Source files
------------

// File: rtl/fan_ctrl_mc.sv
// fan_ctrl_mc: multi-channel PWM fan controller with tachometer-based stall detection.
//
// One prescaler and one PWM counter are shared by all channels. Each channel has its own
// duty/min_duty registers, a compare register, an OFF/SPINUP/RUN/STALL state machine and a
// tach edge counter. All per-channel timing is aligned to the shared period boundary.
//
// Ports:
//   clk_i        - clock
//   rstn_i       - synchronous active-low reset
//   clk_en_i     - clock enable for prescaler, PWM counter and edge counters
//   period_i     - PWM counter terminal value (shared)
//   wr_en_i      - single-cycle write strobe
//   wr_ch_i      - write target channel
//   wr_field_i   - 0 = duty, 1 = min_duty, others ignored
//   wr_data_i    - write data
//   tach_i       - asynchronous tachometer inputs, one per channel
//   pwm_o        - registered PWM outputs
//   stall_o      - per-channel stall flag
//   state_o      - per-channel state, 2 bits each (OFF=0, SPINUP=1, RUN=2, STALL=3)
//   tach_cnt_o   - per-channel edge count from the last completed window, 16 bits each
module fan_ctrl_mc #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned PWM_BITWIDTH   = 8,
  parameter int unsigned PWM_CLK_DIV    = 15,
  parameter int unsigned SPINUP_PERIODS = 16,
  parameter int unsigned TACH_WINDOW    = 2500,
  parameter int unsigned STALL_LIMIT    = 2,
  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clk_en_i,
  input  logic [PWM_BITWIDTH-1:0] period_i,
  input  logic                    wr_en_i,
  input  logic [ChW-1:0]          wr_ch_i,
  input  logic [1:0]              wr_field_i,
  input  logic [PWM_BITWIDTH-1:0] wr_data_i,
  input  logic [NUM_CH-1:0]       tach_i,
  output logic [NUM_CH-1:0]       pwm_o,
  output logic [NUM_CH-1:0]       stall_o,
  output logic [2*NUM_CH-1:0]     state_o,
  output logic [16*NUM_CH-1:0]    tach_cnt_o
);

  localparam int unsigned PreW  = (PWM_CLK_DIV > 0) ? $clog2(PWM_CLK_DIV + 1) : 1;
  localparam int unsigned WinW  = (TACH_WINDOW > 1) ? $clog2(TACH_WINDOW) : 1;
  localparam int unsigned SpinW = (SPINUP_PERIODS > 1) ? $clog2(SPINUP_PERIODS) : 1;
  localparam int unsigned MissW = $clog2(STALL_LIMIT + 1);
  // One extra bit so the spin-up compare exceeds every possible counter value.
  localparam int unsigned CmpW  = PWM_BITWIDTH + 1;

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StSpinup = 2'd1,
    StRun    = 2'd2,
    StStall  = 2'd3
  } state_e;

  // Shared timing
  logic [PreW-1:0]         presc_q, presc_d;
  logic [PWM_BITWIDTH-1:0] cnt_q, cnt_d;
  logic [WinW-1:0]         win_q, win_d;
  logic                    tick, period_end, win_end;

  // Tach synchroniser and edge detect
  logic [NUM_CH-1:0] sync1_q, sync2_q, tach_prev_q;
  logic [NUM_CH-1:0] edge_inc;

  // Per-channel registers
  logic [PWM_BITWIDTH-1:0] duty_q [NUM_CH];
  logic [PWM_BITWIDTH-1:0] duty_d [NUM_CH];
  logic [PWM_BITWIDTH-1:0] min_q  [NUM_CH];
  logic [PWM_BITWIDTH-1:0] min_d  [NUM_CH];
  logic [CmpW-1:0]         cmp_q  [NUM_CH];
  logic [CmpW-1:0]         cmp_d  [NUM_CH];
  logic [15:0]             edge_q [NUM_CH];
  logic [15:0]             edge_d [NUM_CH];
  logic [15:0]             tcnt_q [NUM_CH];
  logic [15:0]             tcnt_d [NUM_CH];
  logic [NUM_CH-1:0]       pwm_q, pwm_d;

  // FSM
  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [SpinW-1:0] spin_q  [NUM_CH];
  logic [SpinW-1:0] spin_d  [NUM_CH];
  logic [MissW-1:0] miss_q  [NUM_CH];
  logic [MissW-1:0] miss_d  [NUM_CH];

  // ---------------------------------------------------------------------------------------------
  // Shared prescaler, PWM counter and window counter
  // ---------------------------------------------------------------------------------------------
  assign tick       = clk_en_i && (presc_q == PreW'(PWM_CLK_DIV));
  assign period_end = tick && (cnt_q == period_i);
  assign win_end    = period_end && (win_q == WinW'(TACH_WINDOW - 1));

  always_comb begin
    presc_d = presc_q;
    if (clk_en_i) begin
      presc_d = (presc_q == PreW'(PWM_CLK_DIV)) ? '0 : presc_q + 1'b1;
    end
    cnt_d = cnt_q;
    if (tick) begin
      // >= keeps the counter bounded if period_i is lowered below the current count.
      cnt_d = (cnt_q >= period_i) ? '0 : cnt_q + 1'b1;
    end
    win_d = win_q;
    if (period_end) begin
      win_d = win_end ? '0 : win_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Per-channel datapath: register writes, edge counting, PWM compare
  // ---------------------------------------------------------------------------------------------
  assign edge_inc = sync2_q & ~tach_prev_q & {NUM_CH{clk_en_i}};

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      duty_d[n] = duty_q[n];
      min_d[n]  = min_q[n];
      if (wr_en_i && (wr_ch_i == ChW'(n))) begin
        if (wr_field_i == 2'd0) duty_d[n] = wr_data_i;
        if (wr_field_i == 2'd1) min_d[n]  = wr_data_i;
      end

      edge_d[n] = edge_q[n];
      tcnt_d[n] = tcnt_q[n];
      if (win_end) begin
        // An edge landing on the window-end cycle belongs to the new window.
        tcnt_d[n] = edge_q[n];
        edge_d[n] = edge_inc[n] ? 16'd1 : 16'd0;
      end else if (edge_inc[n] && (edge_q[n] != 16'hFFFF)) begin
        edge_d[n] = edge_q[n] + 16'd1;
      end

      pwm_d[n] = ({1'b0, cnt_q} < cmp_q[n]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      presc_q     <= '0;
      cnt_q       <= '0;
      win_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      tach_prev_q <= '0;
      pwm_q       <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_q[n] <= '0;
        min_q[n]  <= '0;
        cmp_q[n]  <= '0;
        edge_q[n] <= '0;
        tcnt_q[n] <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      sync1_q     <= tach_i;
      sync2_q     <= sync1_q;
      tach_prev_q <= sync2_q;
      pwm_q       <= pwm_d;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_q[n] <= duty_d[n];
        min_q[n]  <= min_d[n];
        cmp_q[n]  <= cmp_d[n];
        edge_q[n] <= edge_d[n];
        tcnt_q[n] <= tcnt_d[n];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int n = 0; n < NUM_CH; n++) begin
        state_q[n] <= StOff;
        spin_q[n]  <= '0;
        miss_q[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        state_q[n] <= state_d[n];
        spin_q[n]  <= spin_d[n];
        miss_q[n]  <= miss_d[n];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: next state (evaluated only at period_end)
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      state_d[n] = state_q[n];
      spin_d[n]  = spin_q[n];
      miss_d[n]  = miss_q[n];
      if (period_end) begin
        if (duty_q[n] == '0) begin
          state_d[n] = StOff;
          miss_d[n]  = '0;
        end else begin
          unique case (state_q[n])
            StOff: begin
              state_d[n] = StSpinup;
              spin_d[n]  = '0;
            end
            StSpinup: begin
              if (spin_q[n] == SpinW'(SPINUP_PERIODS - 1)) begin
                state_d[n] = StRun;
                miss_d[n]  = '0;
              end else begin
                spin_d[n] = spin_q[n] + 1'b1;
              end
            end
            StRun: begin
              // Uses the count of the window that is closing now.
              if (win_end) begin
                if (edge_q[n] == 16'd0) begin
                  miss_d[n] = miss_q[n] + 1'b1;
                  if (miss_d[n] >= MissW'(STALL_LIMIT)) state_d[n] = StStall;
                end else begin
                  miss_d[n] = '0;
                end
              end
            end
            StStall: begin
              state_d[n] = StStall;
            end
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: outputs and effective compare for the next period
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      cmp_d[n] = cmp_q[n];
      if (period_end) begin
        unique case (state_d[n])
          StSpinup: cmp_d[n] = '1;
          StRun:    cmp_d[n] = {1'b0, (duty_q[n] > min_q[n]) ? duty_q[n] : min_q[n]};
          default:  cmp_d[n] = '0;
        endcase
      end
      stall_o[n]           = (state_q[n] == StStall);
      state_o[2*n +: 2]    = state_q[n];
      tach_cnt_o[16*n +: 16] = tcnt_q[n];
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: tb/tb_fan_ctrl_mc.sv
// Self-checking bench for fan_ctrl_mc. A behavioural model tracks period position, per-channel
// fan state and tach counts with plain integers; DUT outputs are compared every cycle, plus
// directed checks with hand-derived constants.
module tb_fan_ctrl_mc;
  localparam int NCH  = 4;
  localparam int W    = 8;
  localparam int DIV  = 0;
  localparam int SPIN = 4;
  localparam int TW   = 4;
  localparam int SL   = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              clk_en;
  logic [W-1:0]      period;
  logic              wr_en;
  logic [1:0]        wr_ch;
  logic [1:0]        wr_field;
  logic [W-1:0]      wr_data;
  logic [NCH-1:0]    tach;
  logic [NCH-1:0]    pwm;
  logic [NCH-1:0]    stall;
  logic [2*NCH-1:0]  state;
  logic [16*NCH-1:0] tach_cnt;

  fan_ctrl_mc #(
    .NUM_CH         (NCH),
    .PWM_BITWIDTH   (W),
    .PWM_CLK_DIV    (DIV),
    .SPINUP_PERIODS (SPIN),
    .TACH_WINDOW    (TW),
    .STALL_LIMIT    (SL)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .clk_en_i   (clk_en),
    .period_i   (period),
    .wr_en_i    (wr_en),
    .wr_ch_i    (wr_ch),
    .wr_field_i (wr_field),
    .wr_data_i  (wr_data),
    .tach_i     (tach),
    .pwm_o      (pwm),
    .stall_o    (stall),
    .state_o    (state),
    .tach_cnt_o (tach_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [NCH-1:0] tog_mask;

  // Model state: state codes 0=OFF 1=SPINUP 2=RUN 3=STALL
  int m_presc, m_ph, m_win;
  int m_st[NCH], m_duty[NCH], m_min[NCH], m_cmp[NCH];
  int m_spin_left[NCH], m_miss[NCH], m_edges[NCH], m_tcnt[NCH];
  bit m_pwm[NCH], m_s1[NCH], m_s2[NCH], m_prev[NCH];
  bit m_we;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance model and DUT by one clock, then compare all outputs.
  task automatic step();
    bit tk, pe, we;
    logic [NCH-1:0]    e_pwm, e_stall;
    logic [2*NCH-1:0]  e_state;
    logic [16*NCH-1:0] e_tc;
    tk = clk_en && (m_presc == DIV);
    pe = tk && (m_ph == int'(period));
    we = pe && (m_win == TW - 1);
    if (!rstn) begin
      m_presc = 0; m_ph = 0; m_win = 0; m_we = 0;
      for (int n = 0; n < NCH; n++) begin
        m_st[n] = 0; m_duty[n] = 0; m_min[n] = 0; m_cmp[n] = 0; m_spin_left[n] = 0;
        m_miss[n] = 0; m_edges[n] = 0; m_tcnt[n] = 0;
        m_pwm[n] = 0; m_s1[n] = 0; m_s2[n] = 0; m_prev[n] = 0;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        bit rise;
        m_pwm[n] = (m_ph < m_cmp[n]);
        rise = m_s2[n] && !m_prev[n] && clk_en;
        if (pe) begin
          if (m_duty[n] == 0) begin
            m_st[n] = 0; m_miss[n] = 0;
          end else begin
            case (m_st[n])
              0: begin m_st[n] = 1; m_spin_left[n] = SPIN; end
              1: begin
                m_spin_left[n]--;
                if (m_spin_left[n] == 0) begin m_st[n] = 2; m_miss[n] = 0; end
              end
              2: if (we) begin
                if (m_edges[n] == 0) begin
                  m_miss[n]++;
                  if (m_miss[n] >= SL) m_st[n] = 3;
                end else m_miss[n] = 0;
              end
              default: ;
            endcase
          end
          // Spin-up forces the output high for the whole period.
          m_cmp[n] = (m_st[n] == 1) ? (1 << 30) :
                     (m_st[n] == 2) ? ((m_duty[n] > m_min[n]) ? m_duty[n] : m_min[n]) : 0;
        end
        if (we) begin
          m_tcnt[n]  = m_edges[n];
          m_edges[n] = rise ? 1 : 0;
        end else if (rise && m_edges[n] < 65535) m_edges[n]++;
        m_prev[n] = m_s2[n]; m_s2[n] = m_s1[n]; m_s1[n] = tach[n];
        if (wr_en && int'(wr_ch) == n) begin
          if (wr_field == 2'd0) m_duty[n] = int'(wr_data);
          else if (wr_field == 2'd1) m_min[n] = int'(wr_data);
        end
      end
      if (clk_en) m_presc = (m_presc == DIV) ? 0 : m_presc + 1;
      if (tk) m_ph = (m_ph >= int'(period)) ? 0 : m_ph + 1;
      if (pe) m_win = we ? 0 : m_win + 1;
      m_we = we;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc % 3 == 0) tach = tach ^ tog_mask;
    for (int n = 0; n < NCH; n++) begin
      e_pwm[n]           = m_pwm[n];
      e_stall[n]         = (m_st[n] == 3);
      e_state[2*n +: 2]  = 2'(m_st[n]);
      e_tc[16*n +: 16]   = 16'(m_tcnt[n]);
    end
    chk("pwm", 64'(pwm), 64'(e_pwm));
    chk("stall", 64'(stall), 64'(e_stall));
    chk("state", 64'(state), 64'(e_state));
    chk("tach_cnt", tach_cnt, e_tc);
  endtask

  task automatic wr(input int ch, input int field, input int data);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_field = 2'(field); wr_data = W'(data);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_win_end();
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_we) break;
    end
  endtask

  initial begin
    int hi;
    logic [4:0] seq;
    rstn = 1'b0; clk_en = 1'b1; period = 8'd3; wr_en = 1'b0; wr_ch = '0; wr_field = '0;
    wr_data = '0; tach = '0; tog_mask = '0;
    repeat (3) step();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_pwm", 64'(pwm), 64'd0);
    chk("rst_tcnt", tach_cnt, 64'd0);
    rstn = 1'b1;
    tog_mask = 4'b0011;

    // ch0 duty 2 of period 3: spin-up then 50 percent
    wr(0, 0, 2);
    repeat (40) step();
    chk("ch0_run", 64'(state[1:0]), 64'd2);
    hi = 0;
    repeat (8) begin step(); hi += int'(pwm[0]); end
    chk("ch0_duty_half", 64'(hi), 64'd4);

    // ch1 min_duty 3 wins over duty 1, then duty 0 turns it off
    wr(1, 1, 3);
    wr(1, 0, 1);
    repeat (40) step();
    chk("ch1_run", 64'(state[3:2]), 64'd2);
    hi = 0;
    repeat (8) begin step(); hi += int'(pwm[1]); end
    chk("ch1_min_duty", 64'(hi), 64'd6);
    wr(1, 0, 0);
    repeat (5) step();
    chk("ch1_off", 64'(state[3:2]), 64'd0);
    hi = 0;
    repeat (4) begin step(); hi += int'(pwm[1]); end
    chk("ch1_pwm_off", 64'(hi), 64'd0);

    // ch2 runs with no tach: stall after two empty windows
    wr(2, 0, 1);
    for (int i = 0; i < 120 && !stall[2]; i++) step();
    chk("ch2_stall", 64'(stall[2]), 64'd1);
    chk("ch2_state_stall", 64'(state[5:4]), 64'd3);
    hi = 0;
    repeat (4) begin step(); hi += int'(pwm[2]); end
    chk("ch2_pwm_stall", 64'(hi), 64'd0);
    wr(2, 0, 0);
    repeat (5) step();
    chk("ch2_stall_clr", 64'(stall[2]), 64'd0);
    chk("ch2_off", 64'(state[5:4]), 64'd0);

    // ch3: five pulses in one window, then a stuck-high tach
    wait_win_end();
    repeat (5) begin
      tach[3] = 1'b1; step();
      tach[3] = 1'b0; step();
    end
    wait_win_end();
    chk("tach_five", 64'(tach_cnt[63:48]), 64'd5);
    tach[3] = 1'b1;
    wait_win_end();
    chk("tach_stuck_one", 64'(tach_cnt[63:48]), 64'd1);
    wait_win_end();
    chk("tach_stuck_zero", 64'(tach_cnt[63:48]), 64'd0);
    tach[3] = 1'b0;

    // ch0 duty change mid-period: old waveform until the next period starts
    for (int i = 0; i < 8 && m_ph != 1; i++) step();
    wr(0, 0, 1);
    seq[4] = pwm[0];
    for (int i = 3; i >= 0; i--) begin step(); seq[i] = pwm[0]; end
    chk("ch0_midperiod", 64'(seq), 64'b10010);

    // reset during spin-up abandons progress
    wr(1, 0, 1);
    repeat (8) step();
    chk("ch1_spinup", 64'(state[3:2]), 64'd1);
    rstn = 1'b0;
    step();
    chk("rst_mid_state", 64'(state), 64'd0);
    chk("rst_mid_pwm", 64'(pwm), 64'd0);
    chk("rst_mid_stall", 64'(stall), 64'd0);
    rstn = 1'b1;
    repeat (20) step();
    chk("ch1_stays_off", 64'(state[3:2]), 64'd0);

    // randomized traffic against the model
    tog_mask = '0;
    repeat (1500) begin
      clk_en = ($urandom_range(0, 3) != 0);
      tach   = tach ^ NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
      rstn   = ($urandom_range(0, 499) != 0);
      wr_en  = ($urandom_range(0, 9) < 3);
      wr_ch  = 2'($urandom_range(0, 3));
      wr_field = 2'($urandom_range(0, 3));
      wr_data  = W'($urandom_range(0, 5));
      step();
    end
    wr_en = 1'b0; rstn = 1'b1; clk_en = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
